geofence_vec_seq: RTL and testbench

//  Collects one object point and NUM_VERT fence vertices, then issues one vector pair per cycle to the

---
 rtl/geofence_vec_seq.sv | 167 ++++++++++++++++
 tb/tb_geofence_vec_seq.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/geofence_vec_seq.sv
// geofence_vec_seq: collects an object point O and NUM_VERT fence vertices, then issues one
// edge vector pair per cycle (A = V[i]-O, B = V[i+1 mod N]-O) to an external cross-product
// unit. It folds the returned sign bits into an inside/outside verdict for a convex fence.
// Optional feature macro: GEOFENCE_EARLY_EXIT_EN (the first sign mismatch ends the edge scan).
module geofence_vec_seq #(
  parameter int unsigned NUM_VERT = 6,
  parameter int unsigned COORD_W  = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [COORD_W-1:0] in_x,
  input  logic [COORD_W-1:0] in_y,
  output logic               busy,
  output logic               cp_req,
  output logic [COORD_W:0]   ax,
  output logic [COORD_W:0]   ay,
  output logic [COORD_W:0]   bx,
  output logic [COORD_W:0]   by,
  input  logic               cp_cw,
  output logic               out_valid,
  output logic               is_inside
);

  localparam int unsigned VEC_W = COORD_W + 1;
  localparam int unsigned CNT_W = $clog2(NUM_VERT);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VERT - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CALC, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   idx_q, idx_d, nxt_idx;
  logic               ref_q, ref_d;
  logic               mis_q, mis_d;
  logic               ld_o, ld_v;
  logic [COORD_W-1:0] ox_q, oy_q;
  logic [COORD_W-1:0] vx_q [NUM_VERT];
  logic [COORD_W-1:0] vy_q [NUM_VERT];
  logic [VEC_W-1:0]   ax_c, ay_c, bx_c, by_c;
  logic [VEC_W-1:0]   ax_q, ay_q, bx_q, by_q;

  // Edge vectors for the current index; zero-extend then subtract so no overflow is possible.
  always_comb begin
    nxt_idx = (idx_q == LAST_IDX) ? '0 : idx_q + CNT_W'(1);
    ax_c    = {1'b0, vx_q[idx_q]}   - {1'b0, ox_q};
    ay_c    = {1'b0, vy_q[idx_q]}   - {1'b0, oy_q};
    bx_c    = {1'b0, vx_q[nxt_idx]} - {1'b0, ox_q};
    by_c    = {1'b0, vy_q[nxt_idx]} - {1'b0, oy_q};
  end

  // Pair is live while scanning edges, otherwise the last issued pair is held.
  assign ax = cp_req ? ax_c : ax_q;
  assign ay = cp_req ? ay_c : ay_q;
  assign bx = cp_req ? bx_c : bx_q;
  assign by = cp_req ? by_c : by_q;

  // Next-state, counter and sign-accumulation logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ref_d   = ref_q;
    mis_d   = mis_q;
    ld_o    = 1'b0;
    ld_v    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          ld_o    = 1'b1;
          idx_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          ld_v = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            mis_d   = 1'b0;
            state_d = S_CALC;
          end else begin
            idx_d = idx_q + CNT_W'(1);
          end
        end
      end
      S_CALC: begin
        idx_d = nxt_idx;
        if (idx_q == '0) begin
          ref_d = cp_cw;
        end else if (cp_cw != ref_q) begin
          mis_d = 1'b1;
        end
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end
`ifdef GEOFENCE_EARLY_EXIT_EN
        if ((idx_q != '0) && (cp_cw != ref_q)) begin
          idx_d   = '0;
          state_d = S_DONE;
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      ref_q     <= 1'b0;
      mis_q     <= 1'b0;
      busy      <= 1'b0;
      cp_req    <= 1'b0;
      out_valid <= 1'b0;
      is_inside <= 1'b0;
      ax_q      <= '0;
      ay_q      <= '0;
      bx_q      <= '0;
      by_q      <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ref_q     <= ref_d;
      mis_q     <= mis_d;
      busy      <= (state_d == S_CALC) || (state_d == S_DONE);
      cp_req    <= (state_d == S_CALC);
      out_valid <= (state_d == S_DONE);
      if ((state_q == S_CALC) && (state_d == S_DONE)) begin
        is_inside <= ~mis_d;
      end
      if (cp_req) begin
        ax_q <= ax_c;
        ay_q <= ay_c;
        bx_q <= bx_c;
        by_q <= by_c;
      end
    end
  end

  // Point and vertex storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ox_q <= '0;
      oy_q <= '0;
      for (int unsigned k = 0; k < NUM_VERT; k++) begin
        vx_q[k] <= '0;
        vy_q[k] <= '0;
      end
    end else begin
      if (ld_o) begin
        ox_q <= in_x;
        oy_q <= in_y;
      end
      if (ld_v) begin
        vx_q[idx_q] <= in_x;
        vy_q[idx_q] <= in_y;
      end
    end
  end

endmodule

// File: tb/tb_geofence_vec_seq.sv
// Bench for geofence_vec_seq: directed and random fence sets, a behavioural cross-product
// responder, and a per-cycle reference model of the expected pair/handshake/result timeline.
module tb_geofence_vec_seq;

  localparam int unsigned NV = 6;
  localparam int unsigned CW = 10;
  localparam int unsigned VW = CW + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [CW-1:0] in_x = '0;
  logic [CW-1:0] in_y = '0;
  logic          busy, cp_req, cp_cw, out_valid, is_inside;
  logic [VW-1:0] ax, ay, bx, by;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  geofence_vec_seq #(.NUM_VERT(NV), .COORD_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_x(in_x), .in_y(in_y),
    .busy(busy), .cp_req(cp_req), .ax(ax), .ay(ay), .bx(bx), .by(by),
    .cp_cw(cp_cw), .out_valid(out_valid), .is_inside(is_inside)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream cross-product unit: sign of AX*BY - BX*AY.
  int pax, pay, pbx, pby;
  always_comb begin
    pax   = int'($signed(ax));
    pay   = int'($signed(ay));
    pbx   = int'($signed(bx));
    pby   = int'($signed(by));
    cp_cw = ((pax * pby) - (pbx * pay)) < 0;
  end

  // Stimulus set and reference model.
  int s_ox, s_oy;
  int s_vx [NV];
  int s_vy [NV];
  int m_ox, m_oy, m_T, m_L;
  int m_vx [NV];
  int m_vy [NV];
  bit m_active = 1'b0;
  bit m_inside = 1'b0;
  logic [VW-1:0] h_ax = '0, h_ay = '0, h_bx = '0, h_by = '0;
  bit h_inside = 1'b0;
  logic [VW-1:0] first_ax, first_ay;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Geometry decides the verdict: signs of every edge cross product must agree.
  function automatic void build_model();
    bit s [NV];
    int first_bad;
    first_bad = -1;
    for (int i = 0; i < NV; i++) begin
      int j, cax, cay, cbx, cby;
      j   = (i + 1) % NV;
      cax = m_vx[i] - m_ox; cay = m_vy[i] - m_oy;
      cbx = m_vx[j] - m_ox; cby = m_vy[j] - m_oy;
      s[i] = ((cax * cby) - (cbx * cay)) < 0;
      if (i > 0 && s[i] != s[0] && first_bad < 0) first_bad = i;
    end
    m_inside = (first_bad < 0);
`ifdef GEOFENCE_EARLY_EXIT_EN
    m_L = (first_bad < 0) ? NV : first_bad + 1;
`else
    m_L = NV;
`endif
  endfunction

  // Per-cycle check of all outputs against the model timeline.
  int c_d, c_j;
  bit c_calc, c_done;
  logic [VW-1:0] e_ax, e_ay, e_bx, e_by;
  always @(negedge clk) begin : cmp_p
    c_d    = cyc - m_T;
    c_calc = m_active && (c_d >= 0) && (c_d < m_L);
    c_done = m_active && (c_d == m_L);
    if (c_calc) begin
      c_j  = (c_d + 1) % NV;
      e_ax = VW'(m_vx[c_d] - m_ox);
      e_ay = VW'(m_vy[c_d] - m_oy);
      e_bx = VW'(m_vx[c_j] - m_ox);
      e_by = VW'(m_vy[c_j] - m_oy);
      h_ax = e_ax; h_ay = e_ay; h_bx = e_bx; h_by = e_by;
    end else begin
      e_ax = h_ax; e_ay = h_ay; e_bx = h_bx; e_by = h_by;
    end
    if (c_done) h_inside = m_inside;
    chk("cp_req", 32'(cp_req), 32'(c_calc));
    chk("busy", 32'(busy), 32'(c_calc | c_done));
    chk("out_valid", 32'(out_valid), 32'(c_done));
    chk("is_inside", 32'(is_inside), 32'(h_inside));
    chk("ax", 32'(ax), 32'(e_ax));
    chk("ay", 32'(ay), 32'(e_ay));
    chk("bx", 32'(bx), 32'(e_bx));
    chk("by", 32'(by), 32'(e_by));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Drive one set; abort_at >= 0 pulses reset at that edge index instead of finishing.
  task automatic run_set(input bit junk, input int gaps, input int abort_at,
                         output int lat, output bit res);
    int n;
    lat = -1;
    res = 1'b0;
    step();
    in_valid = 1'b1; in_x = CW'(s_ox); in_y = CW'(s_oy);
    step();
    for (int k = 0; k < NV; k++) begin
      if (gaps > 0) begin
        repeat ($urandom_range(gaps, 0)) begin
          in_valid = 1'b0; in_x = CW'($urandom); in_y = CW'($urandom);
          step();
        end
      end
      in_valid = 1'b1; in_x = CW'(s_vx[k]); in_y = CW'(s_vy[k]);
      if (k == NV - 1) begin
        m_ox = s_ox; m_oy = s_oy;
        for (int q = 0; q < NV; q++) begin
          m_vx[q] = s_vx[q]; m_vy[q] = s_vy[q];
        end
        build_model();
        m_T = cyc + 1;
        m_active = 1'b1;
      end
      step();
    end
    first_ax = ax; first_ay = ay;
    in_valid = junk; in_x = CW'($urandom); in_y = CW'($urandom);
    if (abort_at >= 0) begin
      repeat (abort_at) step();
      rst_n = 1'b0;
      m_active = 1'b0;
      h_ax = '0; h_ay = '0; h_bx = '0; h_by = '0; h_inside = 1'b0;
      #1;
      chk("rst_cp_req", 32'(cp_req), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_is_inside", 32'(is_inside), 32'd0);
      chk("rst_ax", 32'(ax), 32'd0);
      chk("rst_by", 32'(by), 32'd0);
      in_valid = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      return;
    end
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
      if (junk) begin
        in_x = CW'($urandom); in_y = CW'($urandom);
      end
    end
    n_cmp++;
    if (!out_valid) begin
      n_err++;
      $display("FAIL out_valid_timeout cycle %0d: got no out_valid, expected one", cyc);
    end else begin
      lat = cyc - m_T + 1;
      res = is_inside;
    end
  endtask

  task automatic load_hex(input int ox, input int oy);
    s_ox = ox; s_oy = oy;
    s_vx[0] = 600; s_vy[0] = 500;
    s_vx[1] = 550; s_vy[1] = 587;
    s_vx[2] = 450; s_vy[2] = 587;
    s_vx[3] = 400; s_vy[3] = 500;
    s_vx[4] = 450; s_vy[4] = 413;
    s_vx[5] = 550; s_vy[5] = 413;
  endtask

  function automatic int clamp(input int v);
    return (v < 0) ? 0 : ((v > 1023) ? 1023 : v);
  endfunction

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int lat;
    bit res;
    int hx [NV];
    int hy [NV];
    hx = '{100, 50, -50, -100, -50, 50};
    hy = '{0, 87, 87, 0, -87, -87};

    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Centre of a regular hexagon: inside, full latency.
    load_hex(500, 500);
    run_set(1'b0, 0, -1, lat, res);
    chk("t1_latency", 32'(lat), 32'd7);
    chk("t1_inside", 32'(res), 32'd1);

    // Outside point: mixed signs.
    load_hex(900, 900);
    run_set(1'b0, 2, -1, lat, res);
    chk("t2_inside", 32'(res), 32'd0);
`ifdef GEOFENCE_EARLY_EXIT_EN
    chk("t2_latency", 32'(lat), 32'd4);
`else
    chk("t2_latency", 32'(lat), 32'd7);
`endif

    // Coordinate extremes.
    s_ox = 0; s_oy = 0;
    s_vx = '{1023, 1023, 700, 100, 0, 300};
    s_vy = '{0, 500, 1000, 1000, 500, 10};
    run_set(1'b0, 1, -1, lat, res);
    chk("t3_ax_max", 32'(first_ax), 32'(11'd1023));
    s_ox = 1023; s_oy = 1023;
    s_vx = '{0, 500, 1000, 1023, 600, 200};
    s_vy = '{0, 10, 300, 900, 1000, 800};
    run_set(1'b0, 0, -1, lat, res);
    chk("t3_ax_min", 32'(first_ax), 32'(11'h401));
    chk("t3_ay_min", 32'(first_ay), 32'(11'h401));

    // Junk input held high through CALC/DONE.
    load_hex(500, 500);
    run_set(1'b1, 0, -1, lat, res);
    chk("t4_latency", 32'(lat), 32'd7);
    chk("t4_inside", 32'(res), 32'd1);

    // Reset in the middle of the edge scan, then a clean set.
    load_hex(500, 500);
    run_set(1'b1, 0, 3, lat, res);
    load_hex(500, 500);
    run_set(1'b0, 0, -1, lat, res);
    chk("t5_inside", 32'(res), 32'd1);

    // Back-to-back sets.
    load_hex(900, 900);
    run_set(1'b1, 0, -1, lat, res);
    chk("t6a_inside", 32'(res), 32'd0);
    load_hex(520, 480);
    run_set(1'b0, 0, -1, lat, res);
    chk("t6b_inside", 32'(res), 32'd1);

    // Random convex hexagons with nearby points, and fully random vertex sets.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(3, 0) != 0) begin
        int cx, cy, r;
        cx = int'($urandom_range(870, 150));
        cy = int'($urandom_range(870, 150));
        r  = int'($urandom_range(140, 20));
        for (int k = 0; k < NV; k++) begin
          s_vx[k] = clamp(cx + (hx[k] * r) / 100);
          s_vy[k] = clamp(cy + (hy[k] * r) / 100);
        end
        s_ox = clamp(cx + int'($urandom_range(300, 0)) - 150);
        s_oy = clamp(cy + int'($urandom_range(300, 0)) - 150);
      end else begin
        for (int k = 0; k < NV; k++) begin
          s_vx[k] = int'($urandom_range(1023, 0));
          s_vy[k] = int'($urandom_range(1023, 0));
        end
        s_ox = int'($urandom_range(1023, 0));
        s_oy = int'($urandom_range(1023, 0));
      end
      run_set(1'($urandom_range(1, 0)), int'($urandom_range(3, 0)), -1, lat, res);
      chk("rnd_inside", 32'(res), 32'(m_inside));
      chk("rnd_latency", 32'(lat), 32'(m_L + 1));
    end

    in_valid = 1'b0;
    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
